// File: rtl/smart_uart_pkg.sv
// Shared definitions for the smart-UART device-side command responder:
// command codes, responder state encoding and err_flags bit positions.
package smart_uart_pkg;

  localparam logic [7:0] SU_CMD_RD_WORD = 8'hA1;
  localparam logic [7:0] SU_CMD_WR_WORD = 8'hA2;
  localparam logic [7:0] SU_CMD_RSP     = 8'hA3;

  typedef enum logic [2:0] {
    SU_IDLE     = 3'd0,
    SU_ADDR     = 3'd1,
    SU_DATA     = 3'd2,
    SU_BUS      = 3'd3,
    SU_RSP_HDR  = 3'd4,
    SU_RSP_DATA = 3'd5
  } su_state_e;

  localparam int ERR_TERM_OVF = 0;
  localparam int ERR_BUS_TO   = 1;
  localparam int ERR_FRAME    = 2;

  function automatic logic su_is_cmd(input logic [7:0] b);
    return (b == SU_CMD_RD_WORD) || (b == SU_CMD_WR_WORD);
  endfunction

endpackage

// File: rtl/smart_uart_tx_arb.sv
// Shares the UART serializer between core console bytes and responder bytes.
// A console byte already offered but not yet accepted keeps the path until it goes.
module smart_uart_tx_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic       rsp_valid,
  input  logic [7:0] rsp_data,
  output logic       rsp_ready,
  input  logic       term_tx_valid,
  input  logic [7:0] term_tx_data,
  output logic       term_tx_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  input  logic       tx_ready
);

  // Handshake: a byte moves in any cycle where valid && ready; a source that
  // raised valid keeps it and its data stable until that cycle.
  logic cons_busy_q;
  logic rsp_sel;

  assign rsp_sel = rsp_valid && !cons_busy_q;

  always_comb begin
    tx_valid      = 1'b0;
    tx_data       = 8'h00;
    term_tx_ready = 1'b0;
    rsp_ready     = 1'b0;
    if (!rst) begin
      if (rsp_sel) begin
        tx_valid  = 1'b1;
        tx_data   = rsp_data;
        rsp_ready = tx_ready;
      end else begin
        tx_valid      = term_tx_valid;
        tx_data       = term_tx_data;
        term_tx_ready = tx_ready;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cons_busy_q <= 1'b0;
    end else begin
      cons_busy_q <= !rsp_sel && term_tx_valid && !tx_ready;
    end
  end

endmodule

// File: rtl/smart_uart_cmd_responder.sv
// Device-side smart-UART endpoint: decodes host read/write frames, runs the
// 32-bit bus access, returns read data and passes other bytes to the terminal.
module smart_uart_cmd_responder
  import smart_uart_pkg::*;
#(
  parameter int          ADDR_W       = 32,
  parameter int          IDLE_TIMEOUT = 2**20,
  parameter int          BUS_TIMEOUT  = 1024,
  parameter logic [31:0] ERR_DATA     = 32'hDEAD_BEEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic              term_rx_valid,
  output logic [7:0]        term_rx_data,
  input  logic              term_rx_ready,
  input  logic              term_tx_valid,
  input  logic [7:0]        term_tx_data,
  output logic              term_tx_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic [2:0]        err_flags
);

  localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);
  localparam int BUS_W  = $clog2(BUS_TIMEOUT + 1);

  su_state_e         state_q, state_d;
  logic              op_wr_q;
  logic [1:0]        byte_cnt_q;
  logic [31:0]       addr_sr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rsp_sr_q;
  logic [IDLE_W-1:0] idle_cnt_q;
  logic [BUS_W-1:0]  bus_cnt_q;
  logic              term_rx_valid_q;
  logic [7:0]        term_rx_data_q;
  logic [2:0]        err_q;

  logic              in_frame;
  logic              idle_expired;
  logic              bus_expired;
  logic              rsp_valid;
  logic [7:0]        rsp_data;
  logic              rsp_ready;

  assign in_frame     = (state_q == SU_ADDR) || (state_q == SU_DATA);
  assign idle_expired = (idle_cnt_q == IDLE_W'(IDLE_TIMEOUT - 1));
  assign bus_expired  = (bus_cnt_q == BUS_W'(BUS_TIMEOUT - 1));

  always_comb begin
    state_d   = state_q;
    rsp_valid = 1'b0;
    rsp_data  = 8'h00;
    case (state_q)
      SU_IDLE: begin
        if (rx_valid && su_is_cmd(rx_data)) state_d = SU_ADDR;
      end
      SU_ADDR: begin
        if (rx_valid) begin
          if (byte_cnt_q == 2'd3) state_d = op_wr_q ? SU_DATA : SU_BUS;
        end else if (idle_expired) begin
          state_d = SU_IDLE;
        end
      end
      SU_DATA: begin
        if (rx_valid) begin
          if (byte_cnt_q == 2'd3) state_d = SU_BUS;
        end else if (idle_expired) begin
          state_d = SU_IDLE;
        end
      end
      SU_BUS: begin
        // An ack arriving on the expiry cycle still counts as a real response.
        if (mem_ack || bus_expired) state_d = op_wr_q ? SU_IDLE : SU_RSP_HDR;
      end
      SU_RSP_HDR: begin
        rsp_valid = 1'b1;
        rsp_data  = SU_CMD_RSP;
        if (rsp_ready) state_d = SU_RSP_DATA;
      end
      SU_RSP_DATA: begin
        rsp_valid = 1'b1;
        rsp_data  = rsp_sr_q[31:24];
        if (rsp_ready && (byte_cnt_q == 2'd3)) state_d = SU_IDLE;
      end
      default: state_d = SU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= SU_IDLE;
      op_wr_q         <= 1'b0;
      byte_cnt_q      <= 2'd0;
      addr_sr_q       <= 32'h0;
      wdata_q         <= 32'h0;
      rsp_sr_q        <= 32'h0;
      idle_cnt_q      <= '0;
      bus_cnt_q       <= '0;
      term_rx_valid_q <= 1'b0;
      term_rx_data_q  <= 8'h00;
      err_q           <= 3'b000;
    end else begin
      state_q         <= state_d;
      term_rx_valid_q <= 1'b0;

      if (in_frame && !rx_valid) idle_cnt_q <= idle_cnt_q + IDLE_W'(1);
      else                       idle_cnt_q <= '0;

      if (state_q == SU_BUS) bus_cnt_q <= bus_cnt_q + BUS_W'(1);
      else                   bus_cnt_q <= '0;

      case (state_q)
        SU_IDLE: begin
          if (rx_valid) begin
            if (su_is_cmd(rx_data)) begin
              op_wr_q    <= (rx_data == SU_CMD_WR_WORD);
              byte_cnt_q <= 2'd0;
            end else if (term_rx_ready) begin
              term_rx_valid_q <= 1'b1;
              term_rx_data_q  <= rx_data;
            end else begin
              err_q[ERR_TERM_OVF] <= 1'b1;
            end
          end
        end
        SU_ADDR, SU_DATA: begin
          // Payload bytes are never re-decoded, even if they match a command.
          if (rx_valid) begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (state_q == SU_ADDR) addr_sr_q <= {addr_sr_q[23:0], rx_data};
            else                    wdata_q   <= {wdata_q[23:0], rx_data};
          end else if (idle_expired) begin
            err_q[ERR_FRAME] <= 1'b1;
          end
        end
        SU_BUS: begin
          if (rx_valid) err_q[ERR_FRAME] <= 1'b1;
          if (mem_ack) begin
            rsp_sr_q   <= mem_rdata;
            byte_cnt_q <= 2'd0;
          end else if (bus_expired) begin
            rsp_sr_q         <= ERR_DATA;
            byte_cnt_q       <= 2'd0;
            err_q[ERR_BUS_TO] <= 1'b1;
          end
        end
        SU_RSP_HDR: begin
          if (rx_valid) err_q[ERR_FRAME] <= 1'b1;
        end
        SU_RSP_DATA: begin
          if (rx_valid) err_q[ERR_FRAME] <= 1'b1;
          if (rsp_ready) begin
            rsp_sr_q   <= {rsp_sr_q[23:0], 8'h00};
            byte_cnt_q <= byte_cnt_q + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_req       = (state_q == SU_BUS);
  assign mem_we        = mem_req && op_wr_q;
  assign mem_addr      = addr_sr_q[ADDR_W-1:0] & ~ADDR_W'(3);
  assign mem_wdata     = wdata_q;
  assign term_rx_valid = term_rx_valid_q;
  assign term_rx_data  = term_rx_data_q;
  assign err_flags     = err_q;

  smart_uart_tx_arb u_tx_arb (
    .clk           (clk),
    .rst           (rst),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .rsp_ready     (rsp_ready),
    .term_tx_valid (term_tx_valid),
    .term_tx_data  (term_tx_data),
    .term_tx_ready (term_tx_ready),
    .tx_valid      (tx_valid),
    .tx_data       (tx_data),
    .tx_ready      (tx_ready)
  );

endmodule

// File: tb/tb_smart_uart_cmd_responder.sv
// Bench for smart_uart_cmd_responder: terminal vector table, read/write frames,
// bus timeout, idle abort, console/response sharing and reset mid-access.
module tb_smart_uart_cmd_responder;
  import smart_uart_pkg::*;

  localparam int ADDR_W  = 32;
  localparam int IDLE_TO = 64;
  localparam int BUS_TO  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              tx_valid;
  logic [7:0]        tx_data;
  logic              tx_ready;
  logic              term_rx_valid;
  logic [7:0]        term_rx_data;
  logic              term_rx_ready;
  logic              term_tx_valid;
  logic [7:0]        term_tx_data;
  logic              term_tx_ready;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;
  logic [2:0]        err_flags;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  smart_uart_cmd_responder #(
    .ADDR_W(ADDR_W), .IDLE_TIMEOUT(IDLE_TO), .BUS_TIMEOUT(BUS_TO), .ERR_DATA(32'hDEAD_BEEF)
  ) dut (
    .clk(clk), .rst(rst),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .term_rx_valid(term_rx_valid), .term_rx_data(term_rx_data), .term_rx_ready(term_rx_ready),
    .term_tx_valid(term_tx_valid), .term_tx_data(term_tx_data), .term_tx_ready(term_tx_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .err_flags(err_flags)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [8:0]  exp_tx_q[$];    // {owned_by_responder, byte}
  logic [7:0]  exp_term_q[$];
  logic [64:0] exp_mem_q[$];   // {we, addr, wdata}
  logic [7:0]  cons_q[$];
  int          ack_delay = 0;
  logic [31:0] bus_rdata = 32'h0;
  int          bus_wait  = 0;
  int          req_len = 0, last_req_len = 0;
  logic        req_prev = 1'b0;
  logic        cons_hs  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got %0h, expected no output", name, act);
  endtask

  // ---------------- output monitor ----------------
  always @(negedge clk) begin
    logic [8:0]  et;
    logic [64:0] em;
    if (rst) begin
      req_prev = 1'b0;
      req_len  = 0;
      cons_hs  = 1'b0;
    end else begin
      cons_hs = term_tx_valid && term_tx_ready;
      if (tx_valid && tx_ready) begin
        if (exp_tx_q.size() == 0) unexpected("tx_byte", tx_data);
        else begin
          et = exp_tx_q.pop_front();
          check("tx_byte", tx_data, et[7:0]);
          if (et[8]) check("term_tx_ready_during_rsp", term_tx_ready, 0);
        end
      end
      if (term_rx_valid) begin
        if (exp_term_q.size() == 0) unexpected("term_rx_byte", term_rx_data);
        else check("term_rx_byte", term_rx_data, exp_term_q.pop_front());
      end
      if (mem_req && !req_prev) begin
        if (exp_mem_q.size() == 0) unexpected("mem_req", mem_addr);
        else begin
          em = exp_mem_q.pop_front();
          check("mem_we", mem_we, em[64]);
          check("mem_addr", mem_addr, em[63:32]);
          if (em[64]) check("mem_wdata", mem_wdata, em[31:0]);
        end
      end
      if (mem_req) req_len++;
      else if (req_prev) begin
        last_req_len = req_len;
        req_len = 0;
      end
      req_prev = mem_req;
    end
  end

  // ---------------- bus and console drivers ----------------
  initial begin : bus_model
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (mem_req && ack_delay >= 0) begin
        if (bus_wait == ack_delay) begin
          mem_ack   = 1'b1;
          mem_rdata = bus_rdata;
          bus_wait  = 0;
        end else bus_wait++;
      end else bus_wait = 0;
    end
  end

  initial begin : console_model
    forever begin
      @(posedge clk); #1;
      if (cons_hs) begin
        if (cons_q.size() != 0) term_tx_data = cons_q.pop_front();
        else term_tx_valid = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    n_fail++;
    $display("FAIL watchdog: got timeout, expected test end");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
  endtask

  task automatic push_rsp(input logic [31:0] d);
    exp_tx_q.push_back({1'b1, SU_CMD_RSP});
    for (int i = 3; i >= 0; i--) exp_tx_q.push_back({1'b1, d[8*i +: 8]});
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_tx_q.size() + exp_term_q.size() + exp_mem_q.size()) != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    check({name, "_drain"}, exp_tx_q.size() + exp_term_q.size() + exp_mem_q.size(), 0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] rx;
    logic       rdy;
    logic       pass;
    logic       err0;
  } term_vec_t;

  term_vec_t vecs[7];

  // ---------------- test sequence ----------------
  initial begin
    int n;
    vecs[0] = '{8'h68, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{8'h69, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{8'h0A, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{8'h68, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{8'h69, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{8'h0A, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{8'hA3, 1'b1, 1'b1, 1'b1};

    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
    term_rx_ready = 1'b1; term_tx_valid = 1'b0; term_tx_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_term_rx_valid", term_rx_valid, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_err_flags", err_flags, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // terminal pass-through vectors
    foreach (vecs[i]) begin
      term_rx_ready = vecs[i].rdy;
      if (vecs[i].pass) exp_term_q.push_back(vecs[i].rx);
      send_byte(vecs[i].rx);
      term_rx_ready = 1'b1;
      @(negedge clk);
      check("term_overflow_flag", err_flags[ERR_TERM_OVF], vecs[i].err0);
    end
    drain("term");

    // read with ack after a few clocks
    ack_delay = 3; bus_rdata = 32'h1234_ABCD;
    exp_mem_q.push_back({1'b0, 32'h0000_0104, 32'h0});
    push_rsp(32'h1234_ABCD);
    send_byte(SU_CMD_RD_WORD);
    send_word(32'h0000_0104);
    @(negedge clk);
    check("rd_req_latency", mem_req, 1);
    drain("read");

    // write, no response expected
    ack_delay = 1;
    exp_mem_q.push_back({1'b1, 32'h8000_0008, 32'hCAFE_F00D});
    send_byte(SU_CMD_WR_WORD);
    send_word(32'h8000_0008);
    send_word(32'hCAFE_F00D);
    @(negedge clk);
    check("wr_req_latency", mem_req, 1);
    drain("write");

    // command codes inside payload, low address bits forced to zero
    exp_mem_q.push_back({1'b1, 32'hA1A2_0004, 32'hA1A2_A3A1});
    send_byte(SU_CMD_WR_WORD);
    send_word(32'hA1A2_0007);
    send_word(32'hA1A2_A3A1);
    drain("write_payload_codes");

    // ack on the very cycle the timeout would expire
    ack_delay = BUS_TO - 1; bus_rdata = 32'h5A5A_0F0F;
    exp_mem_q.push_back({1'b0, 32'h0000_0040, 32'h0});
    push_rsp(32'h5A5A_0F0F);
    send_byte(SU_CMD_RD_WORD);
    send_word(32'h0000_0040);
    drain("ack_at_expiry");
    check("ack_at_expiry_req_len", last_req_len, BUS_TO);
    check("ack_at_expiry_no_bus_err", err_flags[ERR_BUS_TO], 0);

    // bus timeout read
    ack_delay = -1;
    exp_mem_q.push_back({1'b0, 32'h0000_0010, 32'h0});
    push_rsp(32'hDEAD_BEEF);
    send_byte(SU_CMD_RD_WORD);
    send_word(32'h0000_0010);
    drain("bus_timeout");
    check("bus_timeout_req_len", last_req_len, BUS_TO);
    check("bus_timeout_flag", err_flags[ERR_BUS_TO], 1);
    check("frame_flag_still_clear", err_flags[ERR_FRAME], 0);

    // partial frame abandoned by idle timeout
    send_byte(SU_CMD_RD_WORD);
    send_byte(8'h00);
    repeat (IDLE_TO - 4) @(posedge clk);
    @(negedge clk);
    check("idle_before_timeout", err_flags[ERR_FRAME], 0);
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("idle_timeout_flag", err_flags[ERR_FRAME], 1);
    exp_term_q.push_back(8'h78);
    send_byte(8'h78);
    drain("after_idle_abort");

    // console byte pending while a read completes
    ack_delay = 2; bus_rdata = 32'h0BAD_F00D;
    @(posedge clk); #1;
    tx_ready = 1'b0;
    term_tx_valid = 1'b1;
    term_tx_data = 8'h55;
    cons_q.push_back(8'h66);
    exp_tx_q.push_back({1'b0, 8'h55});
    exp_mem_q.push_back({1'b0, 32'h0000_0200, 32'h0});
    push_rsp(32'h0BAD_F00D);
    exp_tx_q.push_back({1'b0, 8'h66});
    send_byte(SU_CMD_RD_WORD);
    send_word(32'h0000_0200);
    n = 0;
    while ((mem_req || exp_mem_q.size() != 0) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("console_read_done", n < 200, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("console_still_offered", tx_data, 8'h55);
    @(posedge clk); #1;
    tx_ready = 1'b1;
    drain("console_share");
    check("console_released", term_tx_valid, 0);

    // reset in the middle of a bus access
    ack_delay = -1;
    exp_mem_q.push_back({1'b0, 32'h0000_0300, 32'h0});
    send_byte(SU_CMD_RD_WORD);
    send_word(32'h0000_0300);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_bus_mem_req", mem_req, 0);
    check("rst_mid_bus_err_flags", err_flags, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    drain("after_reset");

    // byte arriving during a bus access is dropped
    exp_mem_q.push_back({1'b0, 32'h0000_0400, 32'h0});
    push_rsp(32'hDEAD_BEEF);
    send_byte(SU_CMD_RD_WORD);
    send_word(32'h0000_0400);
    send_byte(8'h77);
    drain("rx_during_bus");
    check("rx_during_bus_flags", err_flags, 3'b110);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
